disp_arbiter: RTL and testbench

Shares the 32-bit, 8-digit seven-segment display value between four requesters. A requester asserts its request and presents its data; the block grants the display round-robin. Each grant is held for a minimum number of cycles so every owner's value stays visible. The registered `d_out` drives the display driver's `d` input directly, and a one-cycle `swap` pulse marks every ownership change.

---
 rtl/disp_arbiter.sv | 124 ++++++++++++
 tb/tb_disp_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/disp_arbiter.sv
// Round-robin arbiter sharing one 32-bit display value between four requesters.
// Latency: 1 cycle from sampled req to grant/d_out/swap; owner data tracks d_out with 1-cycle delay.
// Each grant lasts at least HOLD cycles; others wait and are served on the decision edge in round-robin order.
module disp_arbiter #(
  parameter logic [15:0] HOLD = 16'd50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [127:0] src_d,
  output logic [31:0]  d_out,
  output logic [3:0]   grant,
  output logic [1:0]   owner,
  output logic         busy,
  output logic         swap
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  owner_q, owner_d;
  logic [31:0] d_out_q, d_out_d;
  logic        swap_q, swap_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;

  logic        win_vld;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic [31:0] win_dat;
  logic [31:0] own_dat;
  logic        hold_last;

  // Round-robin search starting after the last owner; the last owner itself is checked last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = owner_q;
    cand    = owner_q;
    for (int i = 1; i <= 4; i++) begin
      cand = owner_q + i[1:0];
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_dat   = src_d[{win_idx, 5'b0} +: 32];
  assign own_dat   = src_d[{owner_q, 5'b0} +: 32];
  assign hold_last = (hold_cnt_q == (HOLD - 16'd1));

  // Next-state and output decode; everything holds unless a branch says otherwise.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    d_out_d    = d_out_q;
    swap_d     = 1'b0;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        grant_d = 4'b0000;
        if (win_vld) begin
          state_d    = OWN;
          grant_d    = 4'b0001 << win_idx;
          owner_d    = win_idx;
          d_out_d    = win_dat;
          hold_cnt_d = 16'd0;
          swap_d     = 1'b1;
        end
      end
      OWN: begin
        if (!hold_last) begin
          // Hold period: grant is locked regardless of the owner's request.
          d_out_d    = own_dat;
          hold_cnt_d = hold_cnt_q + 16'd1;
        end else if (!win_vld) begin
          // Nobody wants the display: release it but keep the last value shown.
          state_d = IDLE;
          grant_d = 4'b0000;
        end else if (win_idx != owner_q) begin
          grant_d    = 4'b0001 << win_idx;
          owner_d    = win_idx;
          d_out_d    = win_dat;
          hold_cnt_d = 16'd0;
          swap_d     = 1'b1;
        end else begin
          // Sole requester is the owner: keep tracking its data, counter stays saturated.
          d_out_d = own_dat;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  // State registers with asynchronous reset; owner=3 makes source 0 win first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 4'b0000;
      owner_q    <= 2'd3;
      d_out_q    <= 32'd0;
      swap_q     <= 1'b0;
      hold_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      d_out_q    <= d_out_d;
      swap_q     <= swap_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign d_out = d_out_q;
  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = |grant_q;
  assign swap  = swap_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter with HOLD=4.
// Inputs change 1 time unit after a rising edge; outputs are checked at that point.
// Expected values are hand-derived constants per step.
module tb_disp_arbiter;

  logic         clk;
  logic         clk_en;
  logic         rst;
  logic [3:0]   req;
  logic [31:0]  src [4];
  logic [127:0] src_d;
  logic [31:0]  d_out;
  logic [3:0]   grant;
  logic [1:0]   owner;
  logic         busy;
  logic         swap;

  int checks;
  int errors;

  assign src_d = {src[3], src[2], src[1], src[0]};

  disp_arbiter #(.HOLD(16'd4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .src_d (src_d),
    .d_out (d_out),
    .grant (grant),
    .owner (owner),
    .busy  (busy),
    .swap  (swap)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [31:0] d,
                         input logic [1:0] o, input logic s);
    chk({tag, ".grant"}, {28'd0, grant}, {28'd0, g});
    chk({tag, ".d_out"}, d_out, d);
    chk({tag, ".owner"}, {30'd0, owner}, {30'd0, o});
    chk({tag, ".busy"},  {31'd0, busy},  {31'd0, (g != 4'b0000)});
    chk({tag, ".swap"},  {31'd0, swap},  {31'd0, s});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk_en = 1'b0;
    rst    = 1'b0;
    req    = 4'b0000;
    src[0] = 32'hAAAA_0000;
    src[1] = 32'h1111_1111;
    src[2] = 32'h1234_5678;
    src[3] = 32'h3333_3333;

    // Reset with no clock running.
    #1 rst = 1'b1;
    #1;
    chk_all("reset", 4'b0000, 32'd0, 2'd3, 1'b0);
    #1 rst = 1'b0;
    clk_en = 1'b1;

    // Idle with no requests.
    tick();
    chk_all("idle", 4'b0000, 32'd0, 2'd3, 1'b0);

    // Single requester: source 2.
    req = 4'b0100;
    tick();
    chk_all("single.grant", 4'b0100, 32'h1234_5678, 2'd2, 1'b1);
    tick();
    chk_all("single.hold1", 4'b0100, 32'h1234_5678, 2'd2, 1'b0);
    src[2] = 32'hDEAD_BEEF;
    tick();
    chk_all("single.track", 4'b0100, 32'hDEAD_BEEF, 2'd2, 1'b0);
    tick();
    chk_all("single.hold3", 4'b0100, 32'hDEAD_BEEF, 2'd2, 1'b0);
    tick();
    chk_all("single.keep", 4'b0100, 32'hDEAD_BEEF, 2'd2, 1'b0);
    req = 4'b0000;
    tick();
    chk_all("single.release", 4'b0000, 32'hDEAD_BEEF, 2'd2, 1'b0);

    // Early release: source 1 drops req after one cycle but keeps 4 cycles of grant.
    req = 4'b0010;
    tick();
    chk_all("early.grant", 4'b0010, 32'h1111_1111, 2'd1, 1'b1);
    tick();
    chk_all("early.c1", 4'b0010, 32'h1111_1111, 2'd1, 1'b0);
    req = 4'b0000;
    tick();
    chk_all("early.c2", 4'b0010, 32'h1111_1111, 2'd1, 1'b0);
    tick();
    chk_all("early.c3", 4'b0010, 32'h1111_1111, 2'd1, 1'b0);
    tick();
    chk_all("early.idle", 4'b0000, 32'h1111_1111, 2'd1, 1'b0);

    // Handover on hold expiry: source 0 owns, source 3 requests mid-hold.
    req = 4'b0001;
    tick();
    chk_all("hand.grant0", 4'b0001, 32'hAAAA_0000, 2'd0, 1'b1);
    tick();
    req = 4'b1001;
    tick();
    chk_all("hand.c2", 4'b0001, 32'hAAAA_0000, 2'd0, 1'b0);
    tick();
    chk_all("hand.c3", 4'b0001, 32'hAAAA_0000, 2'd0, 1'b0);
    tick();
    chk_all("hand.grant3", 4'b1000, 32'h3333_3333, 2'd3, 1'b1);

    // Source 2 takes over after source 3's hold, then reset mid-grant.
    req = 4'b0100;
    tick();
    tick();
    tick();
    chk_all("pre_rst.c3", 4'b1000, 32'h3333_3333, 2'd3, 1'b0);
    tick();
    chk_all("pre_rst.grant2", 4'b0100, 32'hDEAD_BEEF, 2'd2, 1'b1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk_all("mid_rst", 4'b0000, 32'd0, 2'd3, 1'b0);
    req = 4'b1111;
    #1 rst = 1'b0;

    // Round robin with all four requesting; source 0 wins first after reset.
    tick();
    chk_all("rr.first", 4'b0001, 32'hAAAA_0000, 2'd0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      int idx;
      tick();
      idx = (i / 4) % 4;
      chk($sformatf("rr.grant%0d", i), {28'd0, grant}, {28'd0, 4'b0001 << idx});
      chk($sformatf("rr.swap%0d", i), {31'd0, swap}, {31'd0, ((i % 4) == 0)});
      chk($sformatf("rr.d_out%0d", i), d_out, src[idx]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
